// File: rtl/serial_alu.sv
// Bit-serial ALU: ADD/SUB/AND/OR evaluated one bit per clock, LSB first.
// Results, flags and a one-cycle done pulse are registered after WIDTH bit cycles.
module serial_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  op_t              r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;

  logic             w_accept;
  logic             w_last;
  logic             w_arith;
  logic             w_ai;
  logic             w_bi;
  logic             w_sum;
  logic             w_carry;
  logic             w_bit;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One-bit slice; SUB is ADD with B inverted and carry-in preset to 1.
  assign w_arith = ~r_op[1];
  assign w_ai    = r_a[0];
  assign w_bi    = r_b[0] ^ (r_op == OP_SUB);
  assign w_sum   = w_ai ^ w_bi ^ r_carry;
  assign w_carry = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);

  always_comb begin
    w_bit = 1'b0;
    case (r_op)
      OP_ADD:  w_bit = w_sum;
      OP_SUB:  w_bit = w_sum;
      OP_AND:  w_bit = r_a[0] & r_b[0];
      OP_OR:   w_bit = r_a[0] | r_b[0];
      default: w_bit = 1'b0;
    endcase
  end

  assign w_res_next = {w_bit, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= OP_ADD;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      y       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_op    <= op_t'(op);
        r_cnt   <= '0;
        r_carry <= (op == OP_SUB);
        busy    <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= w_res_next;
        if (w_arith) r_carry <= w_carry;
        // r_carry still holds the carry into the MSB during the final bit.
        if (w_last) begin
          y    <= w_res_next;
          cout <= w_arith & w_carry;
          ovf  <= w_arith & (r_carry ^ w_carry);
          zero <= (w_res_next == '0);
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule
